// File: rtl/rv_pkg.sv
// Shared constants and types for the fetch/decode path.
package rv_pkg;

    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/pair_fifo.sv
// Show-ahead FIFO of fetched words: one push, pop of 0/1/2 per cycle, flush,
// and read ports for the head entry and the instruction behind it.
module pair_fifo
    import rv_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  fetch_entry_t             push_data,
    input  logic [1:0]               pop_cnt,
    output fetch_entry_t             head,
    output logic [31:0]              head_next_instr,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fetch_entry_t    mem [DEPTH];
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr_nx1;

    assign rd_ptr_nx1      = rd_ptr + AW'(1);
    assign head            = mem[rd_ptr];
    assign head_next_instr = mem[rd_ptr_nx1].instr;

    // Storage is cleared on reset so the head PC reads 0 out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            rd_ptr <= rd_ptr + AW'(pop_cnt);
            count  <= count + CW'(push) - CW'(pop_cnt);
        end
    end

endmodule

// File: rtl/fetch_pair_issue.sv
// Fetches a program window from instruction memory and presents it to the
// dual-issue decoder as older/younger instruction pairs.
//
// state | meaning
// IDLE  | waiting for start, nothing fetched
// FETCH | issuing imem requests until fetch_pc reaches end_pc
// DRAIN | all requests sent; waiting for responses and final issues
// DONE  | window fully issued; done held until next start
module fetch_pair_issue
    import rv_pkg::fetch_entry_t;
#(
    parameter int          DEPTH           = 8,
    parameter int          MAX_OUTSTANDING = 4,
    parameter logic [31:0] NOP_WORD        = rv_pkg::NOP_WORD
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] start_pc,
    input  logic [15:0] num_instr,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] instr_1,
    output logic [31:0] instr_2,
    output logic [31:0] pc_1,
    output logic        valid_1,
    output logic        valid_2,
    input  logic        dec_ready,
    output logic        busy,
    output logic        done
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int OW = $clog2(MAX_OUTSTANDING) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t         state;
    state_t         state_nx;
    logic [31:0]    fetch_pc;
    logic [31:0]    end_pc;
    logic [OW-1:0]  outstanding;
    logic [OW-1:0]  out_next;
    logic [OW-1:0]  drop;

    logic           redirect_act;
    logic           req_fire;
    logic           push;
    logic [1:0]     pop_cnt;
    logic           pair_ok;
    logic           single_ok;
    logic [CW:0]    occupancy;

    fetch_entry_t   head;
    fetch_entry_t   push_data;
    logic [31:0]    head_next_instr;
    logic [CW-1:0]  count;

    assign redirect_act = redirect_valid && (state == FETCH || state == DRAIN);

    // Words buffered plus words in flight must fit, so the FIFO never overflows.
    assign occupancy      = (CW+1)'(count) + (CW+1)'(outstanding);
    assign imem_req_valid = (state == FETCH) && (fetch_pc != end_pc)
                            && (outstanding < OW'(MAX_OUTSTANDING))
                            && (occupancy < (CW+1)'(DEPTH))
                            && !redirect_act;
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign out_next       = outstanding + OW'(req_fire) - OW'(imem_rsp_valid);

    // A lone head entry only issues once nothing else can arrive to pair with it.
    assign pair_ok   = count >= CW'(2);
    assign single_ok = (count == CW'(1)) && (state == DRAIN) && (outstanding == '0);
    assign valid_2   = !redirect_act && pair_ok;
    assign valid_1   = !redirect_act && (pair_ok || single_ok);
    assign instr_1   = valid_1 ? head.instr : NOP_WORD;
    assign instr_2   = valid_2 ? head_next_instr : NOP_WORD;
    assign pc_1      = head.pc;
    assign pop_cnt   = (valid_1 && dec_ready) ? (valid_2 ? 2'd2 : 2'd1) : 2'd0;

    assign push            = imem_rsp_valid && (drop == '0) && !redirect_act;
    assign push_data.instr = imem_rsp_data;
    assign push_data.pc    = fetch_pc - {{(32-OW-2){1'b0}}, outstanding, 2'b00};

    assign busy = (state == FETCH) || (state == DRAIN);
    assign done = (state == DONE);

    pair_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk             (clk),
        .rst             (rst),
        .flush           (redirect_act),
        .push            (push),
        .push_data       (push_data),
        .pop_cnt         (pop_cnt),
        .head            (head),
        .head_next_instr (head_next_instr),
        .count           (count)
    );

    always_comb begin
        state_nx = state;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nx = (num_instr == 16'd0) ? DRAIN : FETCH;
                end
            end
            FETCH: begin
                if (!redirect_act && fetch_pc == end_pc) begin
                    state_nx = DRAIN;
                end
            end
            DRAIN: begin
                if (redirect_act) begin
                    state_nx = FETCH;
                end else if (count == '0 && outstanding == '0) begin
                    state_nx = DONE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            fetch_pc    <= '0;
            end_pc      <= '0;
            outstanding <= '0;
            drop        <= '0;
        end else begin
            state       <= state_nx;
            outstanding <= out_next;
            if ((state == IDLE || state == DONE) && start) begin
                fetch_pc <= start_pc;
                end_pc   <= start_pc + {14'd0, num_instr, 2'b00};
                drop     <= '0;
            end else if (redirect_act) begin
                // Every request still in flight belongs to the abandoned path.
                fetch_pc <= redirect_pc;
                drop     <= out_next;
            end else begin
                if (req_fire) begin
                    fetch_pc <= fetch_pc + 32'd4;
                end
                if (imem_rsp_valid && drop != '0) begin
                    drop <= drop - OW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch_pair_issue.sv
// Randomized bench for fetch_pair_issue: in-order latency memory model plus an
// expected-PC scoreboard derived from the window and redirect rules.
module tb_fetch_pair_issue;

    localparam int          DEPTH = 8;
    localparam int          MAXO  = 4;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] start_pc;
    logic [15:0] num_instr;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] instr_1;
    logic [31:0] instr_2;
    logic [31:0] pc_1;
    logic        valid_1;
    logic        valid_2;
    logic        dec_ready;
    logic        busy;
    logic        done;

    always #5 clk = ~clk;

    fetch_pair_issue #(
        .DEPTH           (DEPTH),
        .MAX_OUTSTANDING (MAXO),
        .NOP_WORD        (NOP)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .start_pc       (start_pc),
        .num_instr      (num_instr),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_1        (instr_1),
        .instr_2        (instr_2),
        .pc_1           (pc_1),
        .valid_1        (valid_1),
        .valid_2        (valid_2),
        .dec_ready      (dec_ready),
        .busy           (busy),
        .done           (done)
    );

    typedef struct {
        logic [31:0] data;
        int          due;
    } rsp_t;

    rsp_t        mq[$];
    logic [31:0] exp_q[$];

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int lat = 1;
    int ready_pct = 100;
    int dec_pct = 100;
    int tb_out = 0;
    int tb_drop = 0;
    int buffered = 0;
    int n_pairs = 0;
    int n_singles = 0;
    bit win_active = 1'b0;
    bit watch_redir = 1'b0;
    logic [31:0] first_pc = '0;
    logic [31:0] next_fetch = '0;
    logic [31:0] end_pc = '0;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    task automatic fill_exp(input logic [31:0] from);
        logic [31:0] p;
        int guard;
        exp_q.delete();
        p = from;
        guard = 0;
        while (p != end_pc && guard < 70000) begin
            exp_q.push_back(p);
            p = p + 32'd4;
            guard++;
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1; start = 1'b0; redirect_valid = 1'b0; imem_rsp_valid = 1'b0;
        imem_req_ready = 1'b0; dec_ready = 1'b0;
        @(negedge clk);
        #1;
        mq.delete(); exp_q.delete();
        tb_out = 0; tb_drop = 0; buffered = 0; win_active = 1'b0;
        n_pairs = 0; n_singles = 0; watch_redir = 1'b0;
    endtask

    task automatic step(input bit do_start, input logic [31:0] s_pc, input logic [15:0] s_n,
                        input bit do_redir, input logic [31:0] r_pc);
        bit rsp, fire, redir_eff, exp_v1, exp_v2, exp_req;
        @(negedge clk);
        rst = 1'b0;
        start = do_start; start_pc = s_pc; num_instr = s_n;
        redirect_valid = do_redir; redirect_pc = r_pc;
        imem_req_ready = ($urandom_range(0, 99) < ready_pct);
        dec_ready = ($urandom_range(0, 99) < dec_pct);
        rsp = (mq.size() > 0) && (mq[0].due <= cyc);
        imem_rsp_valid = rsp;
        imem_rsp_data = rsp ? mq[0].data : 32'h0;
        #1;
        redir_eff = do_redir && win_active;
        exp_v2 = !redir_eff && (buffered >= 2);
        exp_v1 = exp_v2 || (!redir_eff && buffered == 1 && tb_out == 0 && next_fetch == end_pc);
        exp_req = win_active && !redir_eff && (next_fetch != end_pc) && (tb_out < MAXO)
                  && (buffered + tb_out < DEPTH);

        n_cmp++;
        if (valid_1 !== exp_v1) begin
            n_err++; $display("FAIL valid_1 cyc=%0d got=%b exp=%b", cyc, valid_1, exp_v1);
        end
        n_cmp++;
        if (valid_2 !== exp_v2) begin
            n_err++; $display("FAIL valid_2 cyc=%0d got=%b exp=%b", cyc, valid_2, exp_v2);
        end
        n_cmp++;
        if (imem_req_valid !== exp_req) begin
            n_err++; $display("FAIL req_valid cyc=%0d got=%b exp=%b", cyc, imem_req_valid, exp_req);
        end
        if (!exp_v1) begin
            n_cmp++;
            if (instr_1 !== NOP) begin
                n_err++; $display("FAIL instr_1_nop cyc=%0d got=%h exp=%h", cyc, instr_1, NOP);
            end
        end
        if (!exp_v2) begin
            n_cmp++;
            if (instr_2 !== NOP) begin
                n_err++; $display("FAIL instr_2_nop cyc=%0d got=%h exp=%h", cyc, instr_2, NOP);
            end
        end

        if (exp_v1 && dec_ready) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++; $display("FAIL issue_extra cyc=%0d got=pc %h exp=none", cyc, pc_1);
            end else begin
                if (watch_redir) begin
                    first_pc = pc_1;
                    watch_redir = 1'b0;
                end
                n_cmp++;
                if (pc_1 !== exp_q[0]) begin
                    n_err++; $display("FAIL pc_1 cyc=%0d got=%h exp=%h", cyc, pc_1, exp_q[0]);
                end
                n_cmp++;
                if (instr_1 !== word_at(exp_q[0])) begin
                    n_err++; $display("FAIL instr_1 cyc=%0d got=%h exp=%h", cyc, instr_1, word_at(exp_q[0]));
                end
                if (exp_v2) begin
                    n_cmp++;
                    if (exp_q.size() < 2) begin
                        n_err++; $display("FAIL pair_short cyc=%0d got=%0d exp=2", cyc, exp_q.size());
                        void'(exp_q.pop_front());
                    end else begin
                        if (instr_2 !== word_at(exp_q[1])) begin
                            n_err++; $display("FAIL instr_2 cyc=%0d got=%h exp=%h", cyc, instr_2, word_at(exp_q[1]));
                        end
                        void'(exp_q.pop_front());
                        void'(exp_q.pop_front());
                    end
                    n_pairs++;
                    buffered -= 2;
                end else begin
                    n_cmp++;
                    if (exp_q.size() != 1) begin
                        n_err++; $display("FAIL single_early cyc=%0d got=%0d left exp=1", cyc, exp_q.size());
                    end
                    n_cmp++;
                    if (tb_out != 0) begin
                        n_err++; $display("FAIL single_outst cyc=%0d got=%0d exp=0", cyc, tb_out);
                    end
                    void'(exp_q.pop_front());
                    n_singles++;
                    buffered -= 1;
                end
            end
        end

        fire = imem_req_valid && imem_req_ready;
        if (fire) begin
            n_cmp++;
            if (imem_req_addr !== next_fetch) begin
                n_err++; $display("FAIL req_addr cyc=%0d got=%h exp=%h", cyc, imem_req_addr, next_fetch);
            end
            mq.push_back('{data: word_at(imem_req_addr), due: cyc + lat});
            next_fetch = next_fetch + 32'd4;
            tb_out++;
        end
        if (rsp) begin
            void'(mq.pop_front());
            tb_out--;
            if (!redir_eff) begin
                if (tb_drop > 0) tb_drop--;
                else buffered++;
            end
        end
        if (redir_eff) begin
            buffered = 0;
            tb_drop = tb_out;
            next_fetch = r_pc;
            fill_exp(r_pc);
            watch_redir = 1'b1;
        end
        if (do_start && !win_active) begin
            next_fetch = s_pc;
            end_pc = s_pc + {14'd0, s_n, 2'b00};
            fill_exp(s_pc);
            tb_drop = 0;
            win_active = 1'b1;
        end
        cyc++;
    endtask

    task automatic run_until_done(input int budget, input bit allow_redir,
                                  input logic [31:0] base, input int n);
        bit got, redir_used, do_r;
        logic [31:0] rpc;
        got = 1'b0;
        redir_used = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            do_r = 1'b0;
            rpc = '0;
            if (allow_redir && !redir_used && exp_q.size() > 0 && $urandom_range(0, 24) == 0) begin
                do_r = 1'b1;
                redir_used = 1'b1;
                rpc = base + 32'($urandom_range(0, n)) * 32'd4;
            end
            step(1'b0, '0, '0, do_r, rpc);
            if (done === 1'b1) begin
                got = 1'b1;
            end else begin
                n_cmp++;
                if (busy !== 1'b1) begin
                    n_err++; $display("FAIL busy_run cyc=%0d got=%b exp=1", cyc, busy);
                end
            end
        end
        n_cmp++;
        if (!got) begin
            n_err++; $display("FAIL done_timeout cyc=%0d got=0 exp=1", cyc);
        end else begin
            n_cmp++;
            if (exp_q.size() != 0 || tb_out != 0) begin
                n_err++; $display("FAIL done_early cyc=%0d got=%0d left %0d outst exp=0", cyc, exp_q.size(), tb_out);
            end
            n_cmp++;
            if (busy !== 1'b0) begin
                n_err++; $display("FAIL busy_done cyc=%0d got=%b exp=0", cyc, busy);
            end
        end
        win_active = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        n_cmp++; if (valid_1 !== 1'b0) begin n_err++; $display("FAIL rst_valid_1 got=%b exp=0", valid_1); end
        n_cmp++; if (valid_2 !== 1'b0) begin n_err++; $display("FAIL rst_valid_2 got=%b exp=0", valid_2); end
        n_cmp++; if (instr_1 !== NOP) begin n_err++; $display("FAIL rst_instr_1 got=%h exp=%h", instr_1, NOP); end
        n_cmp++; if (instr_2 !== NOP) begin n_err++; $display("FAIL rst_instr_2 got=%h exp=%h", instr_2, NOP); end
        n_cmp++; if (pc_1 !== 32'h0) begin n_err++; $display("FAIL rst_pc_1 got=%h exp=0", pc_1); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy got=%b exp=0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL rst_done got=%b exp=0", done); end
        n_cmp++; if (imem_req_valid !== 1'b0) begin n_err++; $display("FAIL rst_req got=%b exp=0", imem_req_valid); end
    endtask

    task automatic test_window(input logic [15:0] n, input int exp_pairs, input int exp_singles);
        apply_reset();
        lat = 1; ready_pct = 100; dec_pct = 100;
        step(1'b1, 32'h100, n, 1'b0, '0);
        run_until_done(200, 1'b0, '0, 0);
        n_cmp++;
        if (n_pairs != exp_pairs) begin
            n_err++; $display("FAIL pairs_n%0d got=%0d exp=%0d", n, n_pairs, exp_pairs);
        end
        n_cmp++;
        if (n_singles != exp_singles) begin
            n_err++; $display("FAIL singles_n%0d got=%0d exp=%0d", n, n_singles, exp_singles);
        end
    endtask

    task automatic test_zero();
        apply_reset();
        lat = 1; ready_pct = 100; dec_pct = 100;
        step(1'b1, 32'h40, 16'd0, 1'b0, '0);
        step(1'b0, '0, '0, 1'b0, '0);
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL zero_done1 got=%b exp=0", done); end
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL zero_busy1 got=%b exp=1", busy); end
        step(1'b0, '0, '0, 1'b0, '0);
        n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL zero_done2 got=%b exp=1", done); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL zero_busy2 got=%b exp=0", busy); end
        win_active = 1'b0;
        repeat (3) step(1'b0, '0, '0, 1'b0, '0);
        n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL zero_done_hold got=%b exp=1", done); end
    endtask

    task automatic test_backpressure();
        apply_reset();
        lat = 1; ready_pct = 100; dec_pct = 0;
        step(1'b1, 32'h100, 16'd12, 1'b0, '0);
        repeat (20) step(1'b0, '0, '0, 1'b0, '0);
        n_cmp++;
        if (buffered != DEPTH) begin
            n_err++; $display("FAIL bp_fill got=%0d exp=%0d", buffered, DEPTH);
        end
        dec_pct = 100;
        run_until_done(300, 1'b0, '0, 0);
        n_cmp++;
        if (n_pairs != 6) begin
            n_err++; $display("FAIL bp_pairs got=%0d exp=6", n_pairs);
        end
    endtask

    task automatic test_redirect();
        int i;
        apply_reset();
        lat = 4; ready_pct = 100; dec_pct = 100;
        step(1'b1, 32'h100, 16'd128, 1'b0, '0);
        i = 0;
        while (tb_out != 3 && i < 20) begin
            step(1'b0, '0, '0, 1'b0, '0);
            i++;
        end
        step(1'b0, '0, '0, 1'b1, 32'h200);
        n_cmp++;
        if (tb_drop != 3) begin
            n_err++; $display("FAIL redir_drop got=%0d exp=3", tb_drop);
        end
        run_until_done(2000, 1'b0, '0, 0);
        n_cmp++;
        if (first_pc !== 32'h200) begin
            n_err++; $display("FAIL redir_first got=%h exp=%h", first_pc, 32'h200);
        end
    endtask

    task automatic test_random();
        logic [31:0] spc;
        int n;
        for (int it = 0; it < 8; it++) begin
            apply_reset();
            lat = $urandom_range(1, 5);
            ready_pct = $urandom_range(40, 100);
            dec_pct = $urandom_range(30, 100);
            spc = {$urandom(), 2'b00};
            if (it == 0) spc = 32'hFFFF_FFE0;
            n = $urandom_range(0, 40);
            step(1'b1, spc, 16'(n), 1'b0, '0);
            run_until_done(4000, 1'b1, spc, n);
        end
    endtask

    task automatic test_reset_mid();
        int i;
        apply_reset();
        lat = 1; ready_pct = 100; dec_pct = 0;
        step(1'b1, 32'h100, 16'd20, 1'b0, '0);
        i = 0;
        while (buffered != 5 && i < 50) begin
            step(1'b0, '0, '0, 1'b0, '0);
            i++;
        end
        n_cmp++;
        if (buffered != 5) begin
            n_err++; $display("FAIL mid_fill got=%0d exp=5", buffered);
        end
        apply_reset();
        n_cmp++; if (valid_1 !== 1'b0) begin n_err++; $display("FAIL mid_valid_1 got=%b exp=0", valid_1); end
        n_cmp++; if (instr_1 !== NOP) begin n_err++; $display("FAIL mid_instr_1 got=%h exp=%h", instr_1, NOP); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL mid_busy got=%b exp=0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL mid_done got=%b exp=0", done); end
        n_cmp++; if (imem_req_valid !== 1'b0) begin n_err++; $display("FAIL mid_req got=%b exp=0", imem_req_valid); end
        dec_pct = 100;
        step(1'b1, 32'h300, 16'd2, 1'b0, '0);
        run_until_done(100, 1'b0, '0, 0);
        n_cmp++;
        if (n_pairs != 1) begin
            n_err++; $display("FAIL mid_recover got=%0d exp=1", n_pairs);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; start_pc = '0; num_instr = '0;
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        redirect_valid = 1'b0; redirect_pc = '0; dec_ready = 1'b0;
        test_reset();
        test_window(16'd4, 2, 0);
        test_window(16'd3, 1, 1);
        test_zero();
        test_backpressure();
        test_redirect();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
